// File: rtl/ladybird_mem_arbiter.sv
// Two-requester memory port arbiter: data has priority, instruction fetch gets a
// starvation guard, grants hold until the downstream handshake, responses route in order.
module ladybird_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_inst_valid,
    output logic            o_inst_ready,
    input  logic [XLEN-1:0] i_inst_addr,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst_data,
    input  logic            i_data_valid,
    output logic            o_data_ready,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wdata,
    input  logic            i_data_we,
    input  logic [2:0]      i_data_funct,
    output logic            o_data_valid,
    output logic [XLEN-1:0] o_data_rdata,
    output logic            o_mem_valid,
    input  logic            i_mem_ready,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic            o_mem_we,
    output logic [2:0]      o_mem_funct,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_protocol_error
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_q, lock_d, lock_sel_q, lock_sel_d;
    logic [STV_W-1:0]           starve_q, starve_d;
    logic                       perr_q, perr_d;

    logic full, empty, sel_inst, mem_valid, hs, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // While locked the earlier choice is kept so the downstream payload never changes mid-request.
    assign sel_inst  = lock_q ? lock_sel_q
                     : (i_inst_valid & (~i_data_valid | (starve_q == STV_W'(STARVE_LIMIT))));
    assign mem_valid = nrst & (lock_q | i_inst_valid | i_data_valid) & ~full;
    assign hs        = mem_valid & i_mem_ready;
    assign pop       = nrst & i_mem_rvalid & ~empty;
    assign head      = owner_q[rd_ptr_q];

    assign o_mem_valid  = mem_valid;
    assign o_inst_ready = hs & sel_inst;
    assign o_data_ready = hs & ~sel_inst;

    // Fetches are always full-word accesses, so they carry a word funct3 and no write data.
    assign o_mem_addr  = ~nrst ? '0 : (sel_inst ? i_inst_addr : i_data_addr);
    assign o_mem_wdata = (~nrst | sel_inst) ? '0 : i_data_wdata;
    assign o_mem_we    = nrst & ~sel_inst & i_data_we;
    assign o_mem_funct = ~nrst ? 3'b000 : (sel_inst ? 3'b010 : i_data_funct);

    assign o_inst_valid     = pop & head;
    assign o_data_valid     = pop & ~head;
    assign o_inst_data      = (pop & head) ? i_mem_rdata : '0;
    assign o_data_rdata     = (pop & ~head) ? i_mem_rdata : '0;
    assign o_protocol_error = perr_q;

    always_comb begin
        wr_ptr_d   = hs ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        if (hs && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!hs && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (hs) begin
            lock_d = 1'b0;
        end else if (mem_valid) begin
            lock_d     = 1'b1;
            lock_sel_d = sel_inst;
        end

        starve_d = starve_q;
        if (!i_inst_valid || (hs && sel_inst)) begin
            starve_d = '0;
        end else if (hs && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end

        perr_d = perr_q | (i_mem_rvalid & empty);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            owner_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            starve_q   <= '0;
            perr_q     <= 1'b0;
        end else begin
            if (hs) begin
                owner_q[wr_ptr_q] <= sel_inst;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            starve_q   <= starve_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_ladybird_mem_arbiter.sv
// Scenario bench for ladybird_mem_arbiter: reset, grant priority, lock, full, ordering, protocol error.
module tb_ladybird_mem_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            nrst;
    logic            i_inst_valid, o_inst_ready, o_inst_valid;
    logic [XLEN-1:0] i_inst_addr, o_inst_data;
    logic            i_data_valid, o_data_ready, o_data_valid, i_data_we;
    logic [XLEN-1:0] i_data_addr, i_data_wdata, o_data_rdata;
    logic [2:0]      i_data_funct, o_mem_funct;
    logic            o_mem_valid, i_mem_ready, o_mem_we, i_mem_rvalid, o_protocol_error;
    logic [XLEN-1:0] o_mem_addr, o_mem_wdata, i_mem_rdata;

    int total = 0;
    int bad   = 0;

    // Expected response: {owner (1 = inst), data}; mem_q holds the data the downstream model returns.
    logic [XLEN:0]   exp_q[$];
    logic [XLEN-1:0] mem_q[$];

    always #5 clk = ~clk;

    ladybird_mem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready), .i_inst_addr(i_inst_addr),
        .o_inst_valid(o_inst_valid), .o_inst_data(o_inst_data),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .i_data_we(i_data_we), .i_data_funct(i_data_funct),
        .o_data_valid(o_data_valid), .o_data_rdata(o_data_rdata),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_funct(o_mem_funct),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_protocol_error(o_protocol_error)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task drive_idle();
        i_inst_valid = 0; i_inst_addr = '0;
        i_data_valid = 0; i_data_addr = '0; i_data_wdata = '0; i_data_we = 0; i_data_funct = '0;
        i_mem_ready  = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    endtask

    task drive_resp();
        i_mem_rvalid = 1;
        if (mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL drive_resp: no downstream data queued, got size 0 require >0");
            i_mem_rdata = '0;
        end else begin
            i_mem_rdata = mem_q.pop_front();
        end
    endtask

    task check_resp();
        logic [XLEN:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL resp_queue: scoreboard empty at response");
        end else begin
            e = exp_q.pop_front();
            if ({o_inst_valid, o_data_valid} !== {e[XLEN], ~e[XLEN]}) begin
                bad++;
                $display("FAIL resp_route: inst_v/data_v got %b%b require %b%b",
                         o_inst_valid, o_data_valid, e[XLEN], ~e[XLEN]);
            end
            total++;
            if (e[XLEN] ? (o_inst_data !== e[XLEN-1:0] || o_data_rdata !== '0)
                        : (o_data_rdata !== e[XLEN-1:0] || o_inst_data !== '0)) begin
                bad++;
                $display("FAIL resp_data: inst_data=%h data_rdata=%h require owner=%b data=%h",
                         o_inst_data, o_data_rdata, e[XLEN], e[XLEN-1:0]);
            end
        end
    endtask

    task respond();
        @(negedge clk);
        drive_resp();
        #1;
        check_resp();
        @(posedge clk);
        #1;
        i_mem_rvalid = 0;
    endtask

    task issue(input bit is_inst, input logic [XLEN-1:0] addr, input bit we,
               input logic [XLEN-1:0] wdata, input logic [2:0] funct, input logic [XLEN-1:0] rdata);
        bit done;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            i_mem_rvalid = 0;
            i_mem_ready  = 1;
            if (is_inst) begin
                i_inst_valid = 1; i_inst_addr = addr;
            end else begin
                i_data_valid = 1; i_data_addr = addr; i_data_wdata = wdata;
                i_data_we = we; i_data_funct = funct;
            end
            #1;
            if (is_inst ? o_inst_ready : o_data_ready) begin
                done = 1;
                total++;
                if (o_mem_addr !== addr || (is_inst ? o_data_ready : o_inst_ready) !== 1'b0) begin
                    bad++;
                    $display("FAIL issue_addr: addr=%h other_ready=%b require addr=%h other_ready=0",
                             o_mem_addr, is_inst ? o_data_ready : o_inst_ready, addr);
                end
                if (!is_inst) begin
                    total++;
                    if (o_mem_we !== we || o_mem_funct !== funct || o_mem_wdata !== wdata) begin
                        bad++;
                        $display("FAIL issue_payload: we=%b funct=%b wdata=%h require %b %b %h",
                                 o_mem_we, o_mem_funct, o_mem_wdata, we, funct, wdata);
                    end
                end
                exp_q.push_back({is_inst, rdata});
                mem_q.push_back(rdata);
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue_timeout: no ready for addr %h within 20 cycles", addr);
        end
        @(posedge clk);
        #1;
        i_inst_valid = 0;
        i_data_valid = 0;
    endtask

    task test_reset();
        @(negedge clk);
        nrst = 0;
        i_inst_valid = 1; i_inst_addr = 32'h1234; i_data_valid = 1; i_data_addr = 32'h5678;
        i_data_wdata = 32'hFFFF; i_data_we = 1; i_data_funct = 3'b111;
        i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hABCD;
        #1;
        total++;
        if ({o_mem_valid, o_inst_ready, o_data_ready, o_inst_valid, o_data_valid, o_protocol_error} !== 6'b0) begin
            bad++;
            $display("FAIL reset_handshake: got %b require 000000",
                     {o_mem_valid, o_inst_ready, o_data_ready, o_inst_valid, o_data_valid, o_protocol_error});
        end
        total++;
        if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_mem_we !== 0 || o_mem_funct !== '0) begin
            bad++;
            $display("FAIL reset_payload: addr=%h wdata=%h we=%b funct=%b require all 0",
                     o_mem_addr, o_mem_wdata, o_mem_we, o_mem_funct);
        end
        total++;
        if (o_inst_data !== '0 || o_data_rdata !== '0) begin
            bad++;
            $display("FAIL reset_resp_data: inst=%h data=%h require 0", o_inst_data, o_data_rdata);
        end
        @(negedge clk);
        drive_idle();
        nrst = 1;
        #1;
        total++;
        if ({o_mem_valid, o_inst_ready, o_data_ready, o_inst_valid, o_data_valid, o_protocol_error} !== 6'b0
            || o_mem_addr !== '0) begin
            bad++;
            $display("FAIL idle_outputs: flags=%b addr=%h require 0",
                     {o_mem_valid, o_inst_ready, o_data_ready, o_inst_valid, o_data_valid, o_protocol_error},
                     o_mem_addr);
        end
    endtask

    task test_single_inst();
        issue(1, 32'h8000_0000, 0, '0, 3'b010, 32'h0000_0013);
        @(negedge clk);
        respond();
    endtask

    task test_starvation();
        bit exp_inst[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) begin
                i_inst_valid = 1; i_inst_addr = 32'h2000 + 4 * k;
                i_data_valid = 1; i_data_addr = 32'h3000 + 4 * k;
                i_data_we = 0; i_data_funct = 3'b010; i_mem_ready = 1;
            end else begin
                i_inst_valid = 0; i_data_valid = 0;
            end
            if (k > 0) drive_resp();
            else i_mem_rvalid = 0;
            #1;
            if (k > 0) check_resp();
            if (k < 10) begin
                total++;
                if (o_inst_ready !== exp_inst[k] || o_data_ready !== !exp_inst[k]
                    || o_mem_addr !== (exp_inst[k] ? 32'h2000 + 4 * k : 32'h3000 + 4 * k)) begin
                    bad++;
                    $display("FAIL starve_grant[%0d]: inst_rdy=%b data_rdy=%b addr=%h require inst=%b",
                             k, o_inst_ready, o_data_ready, o_mem_addr, exp_inst[k]);
                end
                exp_q.push_back({exp_inst[k], 32'h1000 + k});
                mem_q.push_back(32'h1000 + k);
            end
        end
        @(posedge clk);
        #1;
        i_mem_rvalid = 0;
    endtask

    task test_lock();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_inst_valid = (c < 4);
            i_inst_addr  = 32'h300;
            i_data_valid = (c >= 1);
            i_data_addr  = 32'h400; i_data_we = 0; i_data_funct = 3'b010;
            i_mem_ready  = (c >= 3);
            #1;
            total++;
            if (c < 3) begin
                if (o_mem_valid !== 1 || o_mem_addr !== 32'h300 || o_inst_ready !== 0 || o_data_ready !== 0) begin
                    bad++;
                    $display("FAIL lock_hold[%0d]: valid=%b addr=%h rdy=%b%b require 1 300 00",
                             c, o_mem_valid, o_mem_addr, o_inst_ready, o_data_ready);
                end
            end else if (c == 3) begin
                if (o_inst_ready !== 1 || o_data_ready !== 0 || o_mem_addr !== 32'h300) begin
                    bad++;
                    $display("FAIL lock_grant: rdy=%b%b addr=%h require 10 300",
                             o_inst_ready, o_data_ready, o_mem_addr);
                end
                exp_q.push_back({1'b1, 32'h33}); mem_q.push_back(32'h33);
            end else begin
                if (o_inst_ready !== 0 || o_data_ready !== 1 || o_mem_addr !== 32'h400) begin
                    bad++;
                    $display("FAIL lock_after: rdy=%b%b addr=%h require 01 400",
                             o_inst_ready, o_data_ready, o_mem_addr);
                end
                exp_q.push_back({1'b0, 32'h44}); mem_q.push_back(32'h44);
            end
        end
        @(posedge clk);
        #1;
        i_inst_valid = 0; i_data_valid = 0;
        respond();
        respond();
    endtask

    task test_full();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_data_valid = 1; i_data_we = 0; i_data_funct = 3'b010; i_mem_ready = 1;
            i_data_addr  = (c == 0) ? 32'h500 : (c == 1) ? 32'h504 : 32'h508;
            if (c == 3) drive_resp();
            else i_mem_rvalid = 0;
            #1;
            if (c == 3) check_resp();
            total++;
            if (c < 2 || c == 4) begin
                if (o_mem_valid !== 1 || o_data_ready !== 1 || o_mem_addr !== i_data_addr) begin
                    bad++;
                    $display("FAIL full_grant[%0d]: valid=%b rdy=%b addr=%h require 1 1 %h",
                             c, o_mem_valid, o_data_ready, o_mem_addr, i_data_addr);
                end
                exp_q.push_back({1'b0, 32'h55 + c - (c == 4 ? 2 : 0)});
                mem_q.push_back(32'h55 + c - (c == 4 ? 2 : 0));
            end else if (o_mem_valid !== 0 || o_data_ready !== 0) begin
                bad++;
                $display("FAIL full_block[%0d]: valid=%b rdy=%b require 0 0", c, o_mem_valid, o_data_ready);
            end
        end
        @(posedge clk);
        #1;
        i_data_valid = 0; i_mem_rvalid = 0;
        respond();
        respond();
    endtask

    task test_ordering();
        for (int r = 0; r < 10; r++) begin
            issue(1, 32'h100, 0, '0, 3'b010, 32'hA);
            issue(0, 32'h200, 1, 32'hCAFE_0000 + r, 3'b010, 32'h0);
            respond();
            issue(0, 32'h204, 0, '0, 3'b100, 32'hB);
            respond();
            respond();
        end
    endtask

    task test_protocol_error();
        @(negedge clk);
        i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD;
        #1;
        total++;
        if (o_inst_valid !== 0 || o_data_valid !== 0 || o_inst_data !== '0 || o_data_rdata !== '0) begin
            bad++;
            $display("FAIL perr_no_resp: iv=%b dv=%b id=%h dd=%h require 0",
                     o_inst_valid, o_data_valid, o_inst_data, o_data_rdata);
        end
        @(negedge clk);
        i_mem_rvalid = 0;
        #1;
        total++;
        if (o_protocol_error !== 1) begin
            bad++;
            $display("FAIL perr_set: got %b require 1", o_protocol_error);
        end
        issue(1, 32'h600, 0, '0, 3'b010, 32'h66);
        respond();
        total++;
        if (o_protocol_error !== 1) begin
            bad++;
            $display("FAIL perr_sticky: got %b require 1", o_protocol_error);
        end
        @(negedge clk);
        nrst = 0;
        @(negedge clk);
        nrst = 1;
        #1;
        total++;
        if (o_protocol_error !== 0) begin
            bad++;
            $display("FAIL perr_clear: got %b require 0", o_protocol_error);
        end
        // Leave one request outstanding, then reset: its tracking must be gone afterwards.
        issue(0, 32'h700, 0, '0, 3'b010, 32'h77);
        @(negedge clk);
        nrst = 0;
        exp_q.delete();
        mem_q.delete();
        @(negedge clk);
        nrst = 1;
        i_mem_rvalid = 1; i_mem_rdata = 32'h77;
        #1;
        total++;
        if (o_inst_valid !== 0 || o_data_valid !== 0) begin
            bad++;
            $display("FAIL reset_discard: iv=%b dv=%b require 0 0", o_inst_valid, o_data_valid);
        end
        @(negedge clk);
        i_mem_rvalid = 0;
        #1;
        total++;
        if (o_protocol_error !== 1) begin
            bad++;
            $display("FAIL reset_fifo_empty: perr=%b require 1", o_protocol_error);
        end
    endtask

    initial begin
        nrst = 0;
        drive_idle();
        test_reset();
        test_single_inst();
        test_starvation();
        test_lock();
        test_full();
        test_ordering();
        test_protocol_error();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected responses never seen, require 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ladybird_mem_arbiter.md
Name: ladybird_mem_arbiter

Overview:
- Shares one memory request port between two requesters: the core's instruction-fetch channel and its load/store channel.
- Sits between the pipeline front/memory stages and the memory subsystem (MMU/AXI side).
- Arbitrates requests with fixed data priority plus an instruction anti-starvation guard, and holds the grant stable until the downstream handshake completes.
- Tracks the owner of each outstanding request in an in-order FIFO and routes every in-order response back to its owner.

Parameters:
- XLEN, 32, address/data width.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered downstream requests; power of two, ≥1.
- STARVE_LIMIT, 4, number of consecutive data grants made while an instruction request is waiting before the instruction request is forced to win; ≥1.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- i_inst_valid  in  1  instruction fetch request
- o_inst_ready  out  1  instruction request accepted this cycle
- i_inst_addr  in  XLEN  fetch address
- o_inst_valid  out  1  instruction response
- o_inst_data  out  XLEN  fetched instruction
- i_data_valid  in  1  load/store request
- o_data_ready  out  1  data request accepted this cycle
- i_data_addr  in  XLEN  load/store address
- i_data_wdata  in  XLEN  store data
- i_data_we  in  1  1 = store
- i_data_funct  in  3  funct3 (access size/sign)
- o_data_valid  out  1  data response (loads and stores)
- o_data_rdata  out  XLEN  load data
- o_mem_valid  out  1  downstream request
- i_mem_ready  in  1  downstream accepts
- o_mem_addr  out  XLEN  downstream address
- o_mem_wdata  out  XLEN  downstream write data
- o_mem_we  out  1  downstream write enable
- o_mem_funct  out  3  downstream funct3
- i_mem_rvalid  in  1  downstream response; one per accepted request, in order; always consumed
- i_mem_rdata  in  XLEN  downstream response data
- o_protocol_error  out  1  sticky: response received with no outstanding request

Behaviour:
- Clock and reset: single clock clk; nrst is synchronous, active-low.
- On reset: owner FIFO empty, lock cleared, starvation counter 0, o_protocol_error 0.
  - All valid/ready outputs 0 during the reset cycle.
  - o_mem_addr/wdata/we/funct 0 during the reset cycle.
- Reset mid-operation: all outstanding tracking is discarded. The downstream side shares nrst and must drop its own in-flight requests.
- full = (count == MAX_OUTSTANDING). The request path is combinational (zero-cycle); the response path is combinational from the FIFO head.
- o_mem_valid = (lock | i_inst_valid | i_data_valid) & ~full.
- Selection (sel_inst) when lock = 0:
  - Data wins by default.
  - Instruction wins if only i_inst_valid is asserted.
  - Instruction wins if both are valid and starve_cnt == STARVE_LIMIT.
- Lock: if o_mem_valid & ~i_mem_ready, register lock = 1 and lock_sel = sel_inst. While locked, use lock_sel regardless of new arrivals. Clear the lock on handshake.
- Requesters must hold valid and payload stable until their ready is seen.
- Downstream payload is muxed from the selected requester. The unselected payload is ignored.
- Ready outputs:
  - o_inst_ready = o_mem_valid & i_mem_ready & sel.
  - o_data_ready = o_mem_valid & i_mem_ready & ~sel.
- Handshake pushes the owner bit (1 = inst) into the FIFO.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on a data handshake while i_inst_valid = 1.
  - Clears on an instruction handshake or when i_inst_valid = 0.
  - Holds otherwise.
- Response routing:
  - i_mem_rvalid pops the FIFO head.
  - If head = 1: o_inst_valid = 1 and o_inst_data = i_mem_rdata.
  - If head = 0: o_data_valid = 1 and o_data_rdata = i_mem_rdata.
  - Inactive response outputs read 0.
- Response with FIFO empty: no response output, no pop; o_protocol_error is set and stays set until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, no new request issues even if a pop occurs in the same cycle. Issue resumes the next cycle.
- Pointers wrap modulo MAX_OUTSTANDING.
- Throughput: one request and one response per cycle.

Test Plan:
- Reset then idle: all outputs 0. Single instruction request at addr 0x80000000, i_mem_ready = 1 → o_mem_addr = 0x80000000 and o_inst_ready = 1 in the same cycle. Response rdata 0x00000013 two cycles later → o_inst_valid = 1, o_inst_data = 0x00000013, o_data_valid = 0.
- Both requesters valid every cycle, ready always 1, STARVE_LIMIT = 4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Lock: instruction valid alone, i_mem_ready = 0 for 3 cycles, data request raised in cycle 1 → o_mem_addr stays at the instruction address. The instruction is granted on the ready cycle and data is granted the following cycle.
- Full: MAX_OUTSTANDING = 2, two grants with no response → o_mem_valid = 0. Response in cycle N → no grant in cycle N; grant in cycle N+1.
- Ordering: issue I(0x100), D-store(0x200), D-load(0x204); responses 0xA, 0x0, 0xB → o_inst_data = 0xA, then o_data_valid for the store, then o_data_rdata = 0xB. Repeat 10 times to exercise pointer wrap.
- i_mem_rvalid with FIFO empty → o_protocol_error = 1 and sticky across later traffic. nrst low for 1 cycle → o_protocol_error = 0 and the FIFO is empty.
